move_engine: RTL and testbench
==============================

Name: move_engine

Overview:
- Board/move engine for the 4x4 lights-out game. It is the producer of the `active` and `win_flag` signals that the game-status FSM consumes, and it consumes that FSM's `game_status`.
- It loads a preset board while the player is choosing a board, and applies cursor moves and cell presses during play.
- On every press it pulses `active` so that step_number counts the press. It raises `win_flag` when all cells are off.
- It drives `board` and the cursor outputs to the display logic.

Parameters:
- ROWS, 4, board rows. Fixed; documents the geometry.
- COLS, 4, board columns. Fixed.
- BTN_SYNC, 2, number of synchroniser flops per button before edge detection.

Ports:
- clk_d, input, 1, game clock (the divided clock, shared with the status FSM).
- rst, input, 1, reset. Asynchronous, active-high.
- game_status, input, 2, status from the FSM: 00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
- board_sel, input, 2, preset select; sampled only while in CHOSE_BOARD.
- btn_up / btn_down / btn_left / btn_right / btn_press, input, 1 each, debounced level buttons, asynchronous to clk_d.
- board, output, 16, cell states; bit index = row*4+col; 1 = lit.
- cursor_row, output, 2, cursor row.
- cursor_col, output, 2, cursor column.
- active, output, 1, one-cycle pulse per applied press.
- win_flag, output, 1, registered; high when the board has been solved.

Behaviour:
- Reset values (rst high, asynchronous):
  - board=16'h0000, cursor=(0,0), active=0, win_flag=0.
  - Internal state=IDLE; all synchroniser and edge flops cleared to 0.
- Button path:
  - Each button passes through BTN_SYNC flops plus one history flop.
  - pulse = sync_out & ~history.
  - A button first sampled high at edge N takes effect at edge N+2. A held button produces exactly one pulse.
- Arbitration: at most one action per cycle. Priority is press > up > down > left > right; lower-priority pulses in the same cycle are discarded.
- States:
  - IDLE:
    - Entered on game_status==00 from any state; this overrides all button actions.
    - Every edge: board<=PRESET[board_sel], cursor<=(0,0), win_flag<=0, active<=0.
    - Leaves to PLAY when game_status is 10 or 01.
  - PLAY:
    - up/down: row -/+1 mod 4. left/right: col -/+1 mod 4. Cursor wraps around.
    - Cursor moves never pulse `active`.
    - press: board <= board ^ MASK(row,col). MASK is the cursor cell plus its orthogonal neighbours that lie on the board (no wrap at the edges). active<=1 for exactly that cycle.
    - If the post-press board == 0: win_flag<=1 on the same edge and state<=DONE.
  - DONE:
    - Board and cursor frozen; all buttons ignored; active=0; win_flag held at 1.
    - Leaves to IDLE only when game_status==00.
- game_status 11 while in PLAY (not normally possible): treat as PLAY.
- game_status 01/10 while in IDLE: go to PLAY; the board keeps the preset loaded on the last IDLE edge.
- Boundary cases:
  - A press pulse arriving on the same cycle game_status becomes 00 is dropped: IDLE wins and active stays 0.
  - Reset mid-press: outputs clear immediately. A button still held after reset release produces one pulse, but it acts only if the state is PLAY.
  - A preset equal to 0 is not allowed; all presets are non-zero.

Decomposition:
- Package game_pkg:
  - status localparams CHOSE_BOARD/GAMING/GAME_INITIAL/WINNED, shared with the status FSM.
  - PRESET[0..3] = 16'h0013, 16'h0272, 16'hFFFF, 16'h8421.
  - Function toggle_mask(row,col) returning 16 bits.
- Sub-module btn_edge (synchroniser + rising-edge detect, parameter BTN_SYNC), instantiated 5 times.

Test Plan:
1. rst pulse with game_status=00, board_sel=1. Required: board=0 during reset. At the first edge after release, board=16'h0272, cursor=(0,0), active=0, win_flag=0.
2. board_sel=0, then game_status=10, then btn_press held 5 cycles. Required: 2 edges after the first sample, board=16'h0000, active high for exactly 1 cycle, win_flag=1. Further presses cause no change.
3. board_sel=1, in play: right, down, then press. Required: cursor=(1,1), board=0, win_flag=1. active pulses once in total; the moves produce no pulse.
4. board_sel=2, in play: left, up (expect cursor wraps to (3,3)), then press. Required: board=16'h37FF, active pulses once, win_flag=0.
5. board_sel=2, press and right rise on the same edge. Required: board=16'hFFFF^MASK(0,0)=16'hFFEC, cursor stays (0,0).
6. Mid-game game_status->00 with board_sel=3. Required: next edge board=16'h8421, cursor (0,0), win_flag=0. Separately, rst asserted mid-cycle clears board/active/win_flag without waiting for a clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the lights-out game: status codes, preset boards and
// the press toggle pattern.
package game_pkg;

  localparam logic [1:0] CHOSE_BOARD  = 2'b00;
  localparam logic [1:0] GAMING       = 2'b01;
  localparam logic [1:0] GAME_INITIAL = 2'b10;
  localparam logic [1:0] WINNED       = 2'b11;

  typedef enum logic [1:0] {StIdle, StPlay, StDone} move_state_e;

  function automatic logic [15:0] preset(input logic [1:0] sel);
    logic [15:0] p;
    case (sel)
      2'd0:    p = 16'h0013;
      2'd1:    p = 16'h0272;
      2'd2:    p = 16'hFFFF;
      default: p = 16'h8421;
    endcase
    return p;
  endfunction

  // Cursor cell plus on-board orthogonal neighbours; edges do not wrap.
  function automatic logic [15:0] toggle_mask(input logic [1:0] row, input logic [1:0] col);
    logic [15:0] m;
    m = '0;
    m[{row, col}] = 1'b1;
    if (row != 2'd0) m[{row - 2'd1, col}] = 1'b1;
    if (row != 2'd3) m[{row + 2'd1, col}] = 1'b1;
    if (col != 2'd0) m[{row, col - 2'd1}] = 1'b1;
    if (col != 2'd3) m[{row, col + 2'd1}] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Synchronises one asynchronous level button and emits a single-cycle pulse
// on each rising edge.
module btn_edge
  import game_pkg::*;
#(
  parameter int BTN_SYNC = 2
) (
  input  logic clk_d,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [BTN_SYNC-1:0] sync;
  logic                hist;

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync[0] <= btn;
      for (int i = 1; i < BTN_SYNC; i++) sync[i] <= sync[i-1];
      hist <= sync[BTN_SYNC-1];
    end
  end

  assign pulse = sync[BTN_SYNC-1] & ~hist;

endmodule

// File: rtl/move_engine.sv
// Lights-out board engine: loads presets while a board is chosen, applies
// cursor moves and presses during play, and flags a solved board.
module move_engine
  import game_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int BTN_SYNC = 2
) (
  input  logic                      clk_d,
  input  logic                      rst,
  input  logic [1:0]                game_status,
  input  logic [1:0]                board_sel,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_press,
  output logic [ROWS*COLS-1:0]      board,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic                      active,
  output logic                      win_flag
);

  // Bit order doubles as priority: press, up, down, left, right.
  logic [4:0] btns;
  logic [4:0] pulses;
  assign btns = {btn_right, btn_left, btn_down, btn_up, btn_press};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    btn_edge #(
      .BTN_SYNC(BTN_SYNC)
    ) u_btn_edge (
      .clk_d(clk_d),
      .rst  (rst),
      .btn  (btns[g]),
      .pulse(pulses[g])
    );
  end

  move_state_e       state;
  logic [15:0]       press_board;

  always_comb begin
    press_board = board ^ toggle_mask(cursor_row, cursor_col);
  end

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      board      <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      active     <= 1'b0;
      win_flag   <= 1'b0;
    end else begin
      active <= 1'b0;
      if (game_status == CHOSE_BOARD) begin
        // Board selection overrides any pending button action.
        state      <= StIdle;
        board      <= preset(board_sel);
        cursor_row <= '0;
        cursor_col <= '0;
        win_flag   <= 1'b0;
      end else begin
        case (state)
          StIdle: begin
            board      <= preset(board_sel);
            cursor_row <= '0;
            cursor_col <= '0;
            win_flag   <= 1'b0;
            if (game_status != WINNED) state <= StPlay;
          end
          StPlay: begin
            if (pulses[0]) begin
              board  <= press_board;
              active <= 1'b1;
              if (press_board == '0) begin
                win_flag <= 1'b1;
                state    <= StDone;
              end
            end else if (pulses[1]) begin
              cursor_row <= cursor_row - 2'd1;
            end else if (pulses[2]) begin
              cursor_row <= cursor_row + 2'd1;
            end else if (pulses[3]) begin
              cursor_col <= cursor_col - 2'd1;
            end else if (pulses[4]) begin
              cursor_col <= cursor_col + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_engine.sv
// Bench for move_engine: directed scenarios with literal expectations, then
// randomized play checked every cycle against a cell-level game model.
module tb_move_engine;

  logic        clk_d;
  logic        rst;
  logic [1:0]  game_status;
  logic [1:0]  board_sel;
  logic        btn_up, btn_down, btn_left, btn_right, btn_press;
  logic [15:0] board;
  logic [1:0]  cursor_row, cursor_col;
  logic        active, win_flag;

  move_engine #(
    .ROWS    (4),
    .COLS    (4),
    .BTN_SYNC(2)
  ) dut (
    .clk_d      (clk_d),
    .rst        (rst),
    .game_status(game_status),
    .board_sel  (board_sel),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_press  (btn_press),
    .board      (board),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .active     (active),
    .win_flag   (win_flag)
  );

  initial begin
    clk_d = 1'b0;
    forever #5 clk_d = ~clk_d;
  end

  int checks = 0;
  int errors = 0;
  int act_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] presets [4];
  bit          cells [4][4];
  int          cr, cc, mode;   // mode: 0 choosing, 1 playing, 2 solved
  bit          m_act, m_win;
  logic [4:0]  s1, s2, s3;     // button samples from 1, 2, 3 edges ago

  initial begin
    presets[0] = 16'h0013;
    presets[1] = 16'h0272;
    presets[2] = 16'hFFFF;
    presets[3] = 16'h8421;
  end

  function automatic logic [15:0] mboard();
    logic [15:0] b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r*4+c] = cells[r][c];
    return b;
  endfunction

  task automatic load(input logic [1:0] sel);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) cells[r][c] = presets[sel][r*4+c];
    cr = 0;
    cc = 0;
    m_win = 0;
  endtask

  task automatic press_cell(input int r, input int c);
    int dr [5] = '{0, -1, 1, 0, 0};
    int dc [5] = '{0, 0, 0, -1, 1};
    for (int k = 0; k < 5; k++) begin
      int nr, nc;
      nr = r + dr[k];
      nc = c + dc[k];
      if (nr >= 0 && nr < 4 && nc >= 0 && nc < 4) cells[nr][nc] = ~cells[nr][nc];
    end
  endtask

  task automatic model_step();
    logic [4:0] p;
    if (rst) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) cells[r][c] = 0;
      cr = 0; cc = 0; mode = 0; m_act = 0; m_win = 0;
      s1 = '0; s2 = '0; s3 = '0;
    end else begin
      p = s2 & ~s3;
      m_act = 0;
      if (game_status == 2'b00) begin
        mode = 0;
        load(board_sel);
      end else if (mode == 0) begin
        load(board_sel);
        if (game_status != 2'b11) mode = 1;
      end else if (mode == 1) begin
        if (p[0]) begin
          press_cell(cr, cc);
          m_act = 1;
          if (mboard() == 16'h0) begin
            m_win = 1;
            mode = 2;
          end
        end else if (p[1]) cr = (cr + 3) % 4;
        else if (p[2]) cr = (cr + 1) % 4;
        else if (p[3]) cc = (cc + 3) % 4;
        else if (p[4]) cc = (cc + 1) % 4;
      end
      s3 = s2;
      s2 = s1;
      s1 = {btn_right, btn_left, btn_down, btn_up, btn_press};
    end
  endtask

  always @(posedge clk_d or posedge rst) model_step();

  always @(negedge clk_d) begin
    check("board", {16'h0, board}, {16'h0, mboard()});
    check("cursor_row", {30'h0, cursor_row}, cr);
    check("cursor_col", {30'h0, cursor_col}, cc);
    check("active", {31'h0, active}, {31'h0, m_act});
    check("win_flag", {31'h0, win_flag}, {31'h0, m_win});
    if (active) act_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk_d);
    #1;
  endtask

  task automatic tap(input int idx);
    case (idx)
      0: btn_press = 1'b1;
      1: btn_up    = 1'b1;
      2: btn_down  = 1'b1;
      3: btn_left  = 1'b1;
      default: btn_right = 1'b1;
    endcase
    step(1);
    {btn_right, btn_left, btn_down, btn_up, btn_press} = '0;
    step(3);
  endtask

  task automatic start_game(input logic [1:0] sel, input logic [1:0] st);
    game_status = 2'b00;
    board_sel = sel;
    step(2);
    game_status = st;
    step(2);
  endtask

  int a0;
  bit seen;

  initial begin
    rst = 1'b1;
    game_status = 2'b00;
    board_sel = 2'd1;
    {btn_right, btn_left, btn_down, btn_up, btn_press} = '0;

    // 1: reset, then preset load
    step(2);
    check("t1_board_in_reset", {16'h0, board}, 32'h0);
    rst = 1'b0;
    step(1);
    check("t1_board", {16'h0, board}, 32'h0272);
    check("t1_cursor", {28'h0, cursor_row, cursor_col}, 32'h0);
    check("t1_active", {31'h0, active}, 32'h0);
    check("t1_win", {31'h0, win_flag}, 32'h0);

    // 2: held press on preset 0 solves in one press, two edges after sampling
    start_game(2'd0, 2'b10);
    a0 = act_cnt;
    btn_press = 1'b1;
    step(1);
    step(1);
    check("t2_latency", {16'h0, board}, 32'h0013);
    step(1);
    check("t2_board", {16'h0, board}, 32'h0);
    check("t2_active", {31'h0, active}, 32'h1);
    check("t2_win", {31'h0, win_flag}, 32'h1);
    step(2);
    btn_press = 1'b0;
    step(1);
    check("t2_one_pulse", act_cnt - a0, 32'd1);
    tap(0);
    check("t2_frozen", {16'h0, board}, 32'h0);
    check("t2_no_more_pulse", act_cnt - a0, 32'd1);

    // 3: moves then press on preset 1
    start_game(2'd1, 2'b01);
    a0 = act_cnt;
    tap(4);
    tap(2);
    check("t3_no_move_pulse", act_cnt - a0, 32'd0);
    tap(0);
    check("t3_cursor", {28'h0, cursor_row, cursor_col}, 32'h5);
    check("t3_board", {16'h0, board}, 32'h0);
    check("t3_win", {31'h0, win_flag}, 32'h1);
    check("t3_pulses", act_cnt - a0, 32'd1);

    // 4: wrap to the far corner on preset 2
    start_game(2'd2, 2'b10);
    a0 = act_cnt;
    tap(3);
    tap(1);
    check("t4_cursor", {28'h0, cursor_row, cursor_col}, 32'hF);
    tap(0);
    check("t4_board", {16'h0, board}, 32'h37FF);
    check("t4_pulses", act_cnt - a0, 32'd1);
    check("t4_win", {31'h0, win_flag}, 32'h0);

    // 5: press beats a simultaneous right
    start_game(2'd2, 2'b01);
    btn_press = 1'b1;
    btn_right = 1'b1;
    step(1);
    {btn_right, btn_press} = '0;
    step(3);
    check("t5_board", {16'h0, board}, 32'hFFEC);
    check("t5_cursor", {28'h0, cursor_row, cursor_col}, 32'h0);

    // 6: back to board selection mid-game
    tap(4);
    game_status = 2'b00;
    board_sel = 2'd3;
    step(1);
    check("t6_board", {16'h0, board}, 32'h8421);
    check("t6_cursor", {28'h0, cursor_row, cursor_col}, 32'h0);
    check("t6_win", {31'h0, win_flag}, 32'h0);

    // 6b: asynchronous reset while active is high
    game_status = 2'b01;
    step(2);
    btn_press = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk_d);
      #2;
      seen = active;
    end
    check("t6_active_seen", {31'h0, seen}, 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_board", {16'h0, board}, 32'h0);
    check("t6_rst_active", {31'h0, active}, 32'h0);
    check("t6_rst_win", {31'h0, win_flag}, 32'h0);
    step(2);
    rst = 1'b0;
    step(6);
    btn_press = 1'b0;
    step(2);

    // Randomized play
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) game_status = 2'b00;
      else if (r < 3) game_status = 2'b11;
      else if (r < 10) game_status = 2'($urandom_range(1, 2));
      if ($urandom_range(0, 7) == 0) board_sel = 2'($urandom_range(0, 3));
      btn_press = ($urandom_range(0, 3) == 0);
      btn_up    = ($urandom_range(0, 3) == 0);
      btn_down  = ($urandom_range(0, 3) == 0);
      btn_left  = ($urandom_range(0, 3) == 0);
      btn_right = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
